// File: rtl/bit_serial_fifo_pkg.sv
// Shared sizing and types for the word-in / bit-out transmit FIFO.
// Bit order is selected by BIT_SERIAL_FIFO_MSB_FIRST_EN (undefined: LSB first).
package bit_fifo_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDR_WIDTH    = 2;
  localparam int DEPTH         = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH     = ADDR_WIDTH + 1;
  localparam int BITIDX_WIDTH  = $clog2(DATA_WIDTH);

  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [BITIDX_WIDTH-1:0] bitidx_t;

  localparam bitidx_t LAST_BIT = bitidx_t'(DATA_WIDTH - 1);

  // Maps the running bit counter onto the word bit that goes out on the wire.
  function automatic bitidx_t emit_index(input bitidx_t idx);
`ifdef BIT_SERIAL_FIFO_MSB_FIRST_EN
    return LAST_BIT - idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/bit_serial_fifo_if.sv
// Push/pop and status bundle of the bit-serial transmit FIFO.
// master drives pushes and pops; slave is the FIFO itself.
interface bit_serial_fifo_if;
  import bit_fifo_pkg::*;

  logic                   inWriteEnable;
  word_t                  inData;
  logic                   inReadEnable;
  logic                   outData;
  logic                   outDone;
  logic [CNT_WIDTH-1:0]   outWriteCount;
  bitidx_t                outReadCount;
  logic                   outFull;
  logic                   outEmpty;
  logic                   outAlmostFull;
  logic                   outAlmostEmpty;
  logic                   outWriteError;
  logic                   outReadError;

  modport master (
    output inWriteEnable, inData, inReadEnable,
    input  outData, outDone, outWriteCount, outReadCount, outFull, outEmpty,
           outAlmostFull, outAlmostEmpty, outWriteError, outReadError
  );

  modport slave (
    input  inWriteEnable, inData, inReadEnable,
    output outData, outDone, outWriteCount, outReadCount, outFull, outEmpty,
           outAlmostFull, outAlmostEmpty, outWriteError, outReadError
  );
endinterface

// File: rtl/bit_serial_fifo_mem.sv
// Simple dual-port word store: synchronous write, asynchronous read.
module bit_serial_fifo_mem
  import bit_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  word_t wr_data_i,
  input  addr_t rd_addr_i,
  output word_t rd_data_o
);

  word_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/bit_serial_fifo.sv
// Word-in, bit-out transmit FIFO: buffers words and emits one bit per read strobe.
// Bit order: LSB first by default, MSB first when BIT_SERIAL_FIFO_MSB_FIRST_EN is defined.
module bit_serial_fifo
  import bit_fifo_pkg::*;
(
  input  logic             inClock,
  input  logic             inReset,
  bit_serial_fifo_if.slave fifo_if
);

  ptr_t    wr_ptr_q, wr_ptr_d;
  ptr_t    rd_ptr_q, rd_ptr_d;
  bitidx_t bit_idx_q, bit_idx_d;
  logic    data_q, data_d;
  logic    done_q, done_d;
  logic    wr_err_q, wr_err_d;
  logic    rd_err_q, rd_err_d;

  ptr_t    occupancy;
  logic    full, empty, push_ok, pop_ok, last_bit;
  word_t   head_word;

  // Wrap bit makes the plain difference a correct 0..DEPTH occupancy.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == ptr_t'(DEPTH));
  assign empty     = (occupancy == '0);
  assign push_ok   = fifo_if.inWriteEnable && !full;
  assign pop_ok    = fifo_if.inReadEnable && !empty;
  assign last_bit  = (bit_idx_q == LAST_BIT);

  bit_serial_fifo_mem u_mem (
    .clk       (inClock),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (fifo_if.inData),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (head_word)
  );

  // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    wr_err_d  = fifo_if.inWriteEnable && full;
    rd_err_d  = fifo_if.inReadEnable && empty;

    if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);

    if (pop_ok) begin
      data_d = head_word[emit_index(bit_idx_q)];
      if (last_bit) begin
        bit_idx_d = '0;
        rd_ptr_d  = rd_ptr_q + ptr_t'(1);
        done_d    = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + bitidx_t'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      bit_idx_q <= '0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign fifo_if.outData        = data_q;
  assign fifo_if.outDone        = done_q;
  assign fifo_if.outWriteCount  = occupancy;
  assign fifo_if.outReadCount   = bit_idx_q;
  assign fifo_if.outFull        = full;
  assign fifo_if.outEmpty       = empty;
  assign fifo_if.outAlmostFull  = (occupancy >= ptr_t'(DEPTH - 1));
  assign fifo_if.outAlmostEmpty = (occupancy <= ptr_t'(1));
  assign fifo_if.outWriteError  = wr_err_q;
  assign fifo_if.outReadError   = rd_err_q;

endmodule
